// File: rtl/md_chk_pkg.sv
// Shared definitions for the MD protocol checker: rule indices and width helpers.
package md_chk_pkg;

    localparam int NUM_RULES = 8;

    typedef enum logic [2:0] {
        R0_VALID_DROP    = 3'd0,
        R1_DATA_CHANGE   = 3'd1,
        R2_OFFSET_CHANGE = 3'd2,
        R3_SIZE_CHANGE   = 3'd3,
        R4_SIZE_ZERO     = 3'd4,
        R5_SIZE_OVERFLOW = 3'd5,
        R6_ERR_NO_XFER   = 3'd6,
        R7_TIMEOUT       = 3'd7
    } rule_e;

    // Byte offset field width; never narrower than one bit.
    function automatic int offset_width(input int data_width);
        int w;
        w = $clog2(data_width / 8);
        return (w < 1) ? 1 : w;
    endfunction

    // Byte count field width; must be able to hold the full bus width in bytes.
    function automatic int size_width(input int data_width);
        return $clog2(data_width / 8) + 1;
    endfunction

    // Channel index width; at least one bit even for a single channel.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Stall counter width; must represent the timeout value itself.
    function automatic int stall_width(input int timeout_cycles);
        return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/md_chk_channel.sv
// One monitored MD channel: transfer tracking, rule evaluation, stall timer
// and saturating transfer/error counters. Rule outputs are combinational on
// the current cycle's inputs; the top level registers them.
module md_chk_channel
    import md_chk_pkg::*;
#(
    parameter int  DATA_WIDTH     = 32,
    parameter int  TIMEOUT_CYCLES = 256,
    parameter int  CNT_WIDTH      = 16,
    localparam int OFFSET_WIDTH   = offset_width(DATA_WIDTH),
    localparam int SIZE_WIDTH     = size_width(DATA_WIDTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    valid_i,
    input  logic                    ready_i,
    input  logic                    err_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic [OFFSET_WIDTH-1:0] offset_i,
    input  logic [SIZE_WIDTH-1:0]   size_i,
    input  logic                    clr_i,
    output logic [NUM_RULES-1:0]    rules_o,
    output logic [CNT_WIDTH-1:0]    xfer_cnt_o,
    output logic [CNT_WIDTH-1:0]    err_cnt_o
);

    localparam int STALL_WIDTH = stall_width(TIMEOUT_CYCLES);
    localparam int SUM_WIDTH   = SIZE_WIDTH + 1;
    localparam logic [STALL_WIDTH-1:0] STALL_MAX  = STALL_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [STALL_WIDTH-1:0] STALL_FIRE =
        STALL_WIDTH'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [SUM_WIDTH-1:0]   BUS_BYTES  = SUM_WIDTH'(DATA_WIDTH / 8);
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]   CNT_MAX    = '1;

    logic                    pend_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [OFFSET_WIDTH-1:0] offset_q;
    logic [SIZE_WIDTH-1:0]   size_q;
    logic [STALL_WIDTH-1:0]  stall_q, stall_d;
    logic [CNT_WIDTH-1:0]    xfer_q, xfer_d;
    logic [CNT_WIDTH-1:0]    err_q, err_d;
    logic                    xfer_s, stall_s, timeout_s;
    logic [SUM_WIDTH-1:0]    extent_s;

    assign xfer_s   = valid_i & ready_i;
    assign stall_s  = valid_i & ~ready_i;
    assign extent_s = {1'b0, size_i} + SUM_WIDTH'(offset_i);

    // Stall timer: counts consecutive stalled cycles, saturates at the timeout
    // so the timeout rule fires only on the cycle it is first reached.
    always_comb begin
        stall_d   = '0;
        timeout_s = 1'b0;
        if (stall_s) begin
            if (stall_q == STALL_MAX) begin
                stall_d = stall_q;
            end else begin
                stall_d = stall_q + STALL_WIDTH'(1);
            end
            timeout_s = (TIMEOUT_CYCLES > 0) && (stall_q == STALL_FIRE);
        end else begin
            stall_d = '0;
        end
    end

    // Rule evaluation on this cycle's inputs against the held transfer fields.
    always_comb begin
        rules_o                   = '0;
        rules_o[R0_VALID_DROP]    = pend_q & ~valid_i;
        rules_o[R1_DATA_CHANGE]   = pend_q & valid_i & (data_i != data_q);
        rules_o[R2_OFFSET_CHANGE] = pend_q & valid_i & (offset_i != offset_q);
        rules_o[R3_SIZE_CHANGE]   = pend_q & valid_i & (size_i != size_q);
        rules_o[R4_SIZE_ZERO]     = valid_i & (size_i == '0);
        rules_o[R5_SIZE_OVERFLOW] = valid_i & (extent_s > BUS_BYTES);
        rules_o[R6_ERR_NO_XFER]   = err_i & ~xfer_s;
        rules_o[R7_TIMEOUT]       = timeout_s;
    end

    // Saturating counters; a clear coinciding with a transfer restarts at one.
    always_comb begin
        xfer_d = xfer_q;
        err_d  = err_q;
        if (clr_i) begin
            xfer_d = xfer_s ? CNT_ONE : '0;
            err_d  = (xfer_s && err_i) ? CNT_ONE : '0;
        end else begin
            if (xfer_s && (xfer_q != CNT_MAX)) begin
                xfer_d = xfer_q + CNT_ONE;
            end else begin
                xfer_d = xfer_q;
            end
            if (xfer_s && err_i && (err_q != CNT_MAX)) begin
                err_d = err_q + CNT_ONE;
            end else begin
                err_d = err_q;
            end
        end
    end

    // Tracking state: pending flag, fields held while a transfer is pending.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q   <= 1'b0;
            data_q   <= '0;
            offset_q <= '0;
            size_q   <= '0;
            stall_q  <= '0;
            xfer_q   <= '0;
            err_q    <= '0;
        end else begin
            pend_q  <= stall_s;
            stall_q <= stall_d;
            xfer_q  <= xfer_d;
            err_q   <= err_d;
            if (!pend_q) begin
                data_q   <= data_i;
                offset_q <= offset_i;
                size_q   <= size_i;
            end else begin
                data_q   <= data_q;
                offset_q <= offset_q;
                size_q   <= size_q;
            end
        end
    end

    assign xfer_cnt_o = xfer_q;
    assign err_cnt_o  = err_q;

endmodule

// File: rtl/md_protocol_checker.sv
// Multi-channel MD valid/ready protocol checker: sticky violation status,
// interrupt, first-violation capture and per-channel counters.
// Optional macro MD_PROTOCOL_CHECKER_CAPTURE_EN adds capture of the violating
// channel's data/offset/size and a cycle timestamp.
module md_protocol_checker
    import md_chk_pkg::*;
#(
    parameter int  DATA_WIDTH     = 32,
    parameter int  NUM_CH         = 2,
    parameter int  TIMEOUT_CYCLES = 256,
    parameter int  CNT_WIDTH      = 16,
    localparam int OFFSET_WIDTH   = offset_width(DATA_WIDTH),
    localparam int SIZE_WIDTH     = size_width(DATA_WIDTH),
    localparam int CH_WIDTH       = ch_width(NUM_CH)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_CH-1:0]              md_valid,
    input  logic [NUM_CH-1:0]              md_ready,
    input  logic [NUM_CH-1:0]              md_err,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   md_data,
    input  logic [NUM_CH*OFFSET_WIDTH-1:0] md_offset,
    input  logic [NUM_CH*SIZE_WIDTH-1:0]   md_size,
    input  logic [NUM_CH-1:0]              checks_enable,
    input  logic                           clr,
    output logic [NUM_CH*8-1:0]            viol_status,
    output logic                           irq,
    output logic                           first_viol_valid,
    output logic [CH_WIDTH-1:0]            first_viol_ch,
    output logic [2:0]                     first_viol_rule,
`ifdef MD_PROTOCOL_CHECKER_CAPTURE_EN
    output logic [DATA_WIDTH-1:0]          first_viol_data,
    output logic [OFFSET_WIDTH-1:0]        first_viol_offset,
    output logic [SIZE_WIDTH-1:0]          first_viol_size,
    output logic [31:0]                    first_viol_stamp,
`endif
    output logic [NUM_CH*CNT_WIDTH-1:0]    xfer_cnt,
    output logic [NUM_CH*CNT_WIDTH-1:0]    err_cnt
);

    if ((DATA_WIDTH < 8) || ((DATA_WIDTH & (DATA_WIDTH - 1)) != 0)) begin : g_bad_data_width
        $fatal(1, "md_protocol_checker: DATA_WIDTH must be a power of 2 and >= 8");
    end
    if ((NUM_CH < 1) || (NUM_CH > 16)) begin : g_bad_num_ch
        $fatal(1, "md_protocol_checker: NUM_CH must be in 1..16");
    end

    logic [NUM_CH*NUM_RULES-1:0] new_viol_s;
    logic [NUM_CH*NUM_RULES-1:0] status_q, status_d;
    logic                        irq_q, irq_d;
    logic                        hit_s;
    logic [CH_WIDTH-1:0]         hit_ch_s;
    rule_e                       hit_rule_s;
    logic                        fv_valid_q, fv_valid_d;
    logic [CH_WIDTH-1:0]         fv_ch_q, fv_ch_d;
    logic [2:0]                  fv_rule_q, fv_rule_d;
`ifdef MD_PROTOCOL_CHECKER_CAPTURE_EN
    logic [DATA_WIDTH-1:0]       hit_data_s, fv_data_q, fv_data_d;
    logic [OFFSET_WIDTH-1:0]     hit_offset_s, fv_offset_q, fv_offset_d;
    logic [SIZE_WIDTH-1:0]       hit_size_s, fv_size_q, fv_size_d;
    logic [31:0]                 stamp_q, fv_stamp_q, fv_stamp_d;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [NUM_RULES-1:0] rules_s;

        md_chk_channel #(
            .DATA_WIDTH     (DATA_WIDTH),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
            .CNT_WIDTH      (CNT_WIDTH)
        ) u_channel (
            .clk_i      (clk),
            .rst_ni     (reset_n),
            .valid_i    (md_valid[c]),
            .ready_i    (md_ready[c]),
            .err_i      (md_err[c]),
            .data_i     (md_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .offset_i   (md_offset[c*OFFSET_WIDTH +: OFFSET_WIDTH]),
            .size_i     (md_size[c*SIZE_WIDTH +: SIZE_WIDTH]),
            .clr_i      (clr),
            .rules_o    (rules_s),
            .xfer_cnt_o (xfer_cnt[c*CNT_WIDTH +: CNT_WIDTH]),
            .err_cnt_o  (err_cnt[c*CNT_WIDTH +: CNT_WIDTH])
        );

        assign new_viol_s[c*NUM_RULES +: NUM_RULES] = rules_s & {NUM_RULES{checks_enable[c]}};
    end

    // Priority select: scan from highest to lowest so the lowest channel,
    // then the lowest rule index, is the one left standing.
    always_comb begin
        hit_s      = 1'b0;
        hit_ch_s   = '0;
        hit_rule_s = R0_VALID_DROP;
`ifdef MD_PROTOCOL_CHECKER_CAPTURE_EN
        hit_data_s   = '0;
        hit_offset_s = '0;
        hit_size_s   = '0;
`endif
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            for (int r = NUM_RULES - 1; r >= 0; r--) begin
                if (new_viol_s[c*NUM_RULES + r]) begin
                    hit_s      = 1'b1;
                    hit_ch_s   = CH_WIDTH'(c);
                    hit_rule_s = rule_e'(3'(r));
`ifdef MD_PROTOCOL_CHECKER_CAPTURE_EN
                    hit_data_s   = md_data[c*DATA_WIDTH +: DATA_WIDTH];
                    hit_offset_s = md_offset[c*OFFSET_WIDTH +: OFFSET_WIDTH];
                    hit_size_s   = md_size[c*SIZE_WIDTH +: SIZE_WIDTH];
`endif
                end else begin
                    hit_s = hit_s;
                end
            end
        end
    end

    // Sticky status and interrupt; new violations survive a same-cycle clear.
    always_comb begin
        status_d = clr ? new_viol_s : (status_q | new_viol_s);
        irq_d    = |status_d;
    end

    // First-violation capture: load once, hold until clear; a violation in the
    // clearing cycle is captured fresh (selected fields are zero with no hit).
    always_comb begin
        fv_valid_d = fv_valid_q;
        fv_ch_d    = fv_ch_q;
        fv_rule_d  = fv_rule_q;
`ifdef MD_PROTOCOL_CHECKER_CAPTURE_EN
        fv_data_d   = fv_data_q;
        fv_offset_d = fv_offset_q;
        fv_size_d   = fv_size_q;
        fv_stamp_d  = fv_stamp_q;
`endif
        if (clr || (!fv_valid_q && hit_s)) begin
            fv_valid_d = hit_s;
            fv_ch_d    = hit_ch_s;
            fv_rule_d  = hit_rule_s;
`ifdef MD_PROTOCOL_CHECKER_CAPTURE_EN
            fv_data_d   = hit_data_s;
            fv_offset_d = hit_offset_s;
            fv_size_d   = hit_size_s;
            fv_stamp_d  = hit_s ? stamp_q : 32'd0;
`endif
        end else begin
            fv_valid_d = fv_valid_q;
        end
    end

    // Status, interrupt and capture registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            status_q   <= '0;
            irq_q      <= 1'b0;
            fv_valid_q <= 1'b0;
            fv_ch_q    <= '0;
            fv_rule_q  <= 3'd0;
`ifdef MD_PROTOCOL_CHECKER_CAPTURE_EN
            fv_data_q   <= '0;
            fv_offset_q <= '0;
            fv_size_q   <= '0;
            fv_stamp_q  <= 32'd0;
            stamp_q     <= 32'd0;
`endif
        end else begin
            status_q   <= status_d;
            irq_q      <= irq_d;
            fv_valid_q <= fv_valid_d;
            fv_ch_q    <= fv_ch_d;
            fv_rule_q  <= fv_rule_d;
`ifdef MD_PROTOCOL_CHECKER_CAPTURE_EN
            fv_data_q   <= fv_data_d;
            fv_offset_q <= fv_offset_d;
            fv_size_q   <= fv_size_d;
            fv_stamp_q  <= fv_stamp_d;
            stamp_q     <= stamp_q + 32'd1;
`endif
        end
    end

    assign viol_status      = status_q;
    assign irq              = irq_q;
    assign first_viol_valid = fv_valid_q;
    assign first_viol_ch    = fv_ch_q;
    assign first_viol_rule  = fv_rule_q;
`ifdef MD_PROTOCOL_CHECKER_CAPTURE_EN
    assign first_viol_data   = fv_data_q;
    assign first_viol_offset = fv_offset_q;
    assign first_viol_size   = fv_size_q;
    assign first_viol_stamp  = fv_stamp_q;
`endif

endmodule

// File: tb/tb_md_protocol_checker.sv
// Directed, table-driven bench for md_protocol_checker
// (DATA_WIDTH=32, NUM_CH=2, TIMEOUT_CYCLES=4, default build).
module tb_md_protocol_checker;

    localparam logic [31:0] DA = 32'hA5A5A5A5;
    localparam logic [31:0] D5 = 32'h5A5A5A5A;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  md_valid, md_ready, md_err, checks_enable;
    logic [63:0] md_data;
    logic [3:0]  md_offset;
    logic [5:0]  md_size;
    logic        clr;
    logic [15:0] viol_status;
    logic        irq, first_viol_valid;
    logic [0:0]  first_viol_ch;
    logic [2:0]  first_viol_rule;
    logic [31:0] xfer_cnt, err_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    md_protocol_checker #(
        .DATA_WIDTH(32), .NUM_CH(2), .TIMEOUT_CYCLES(4), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .md_valid(md_valid), .md_ready(md_ready),
        .md_err(md_err), .md_data(md_data), .md_offset(md_offset), .md_size(md_size),
        .checks_enable(checks_enable), .clr(clr), .viol_status(viol_status), .irq(irq),
        .first_viol_valid(first_viol_valid), .first_viol_ch(first_viol_ch),
        .first_viol_rule(first_viol_rule), .xfer_cnt(xfer_cnt), .err_cnt(err_cnt)
    );

    typedef struct {
        logic [1:0]  v, r, e, en;
        logic        c;
        logic [31:0] d1;
        logic [2:0]  sz0;
        logic [1:0]  off0;
        logic [2:0]  sz1;
        logic [15:0] st;
        logic        fv;
        logic        ch;
        logic [2:0]  rule;
        logic [15:0] x0, x1, e0;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] v, input logic [1:0] r, input logic [1:0] e,
                                input logic [1:0] en, input logic c, input logic [31:0] d1,
                                input logic [2:0] sz0, input logic [1:0] off0, input logic [2:0] sz1,
                                input logic [15:0] st, input logic fv, input logic ch,
                                input logic [2:0] rule, input logic [15:0] x0,
                                input logic [15:0] x1, input logic [15:0] e0);
        vec_t t;
        t.v = v; t.r = r; t.e = e; t.en = en; t.c = c; t.d1 = d1;
        t.sz0 = sz0; t.off0 = off0; t.sz1 = sz1; t.st = st; t.fv = fv;
        t.ch = ch; t.rule = rule; t.x0 = x0; t.x1 = x1; t.e0 = e0;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] st, input logic fv,
                             input logic ch, input logic [2:0] rule, input logic [15:0] x0,
                             input logic [15:0] x1, input logic [15:0] e0, input logic [15:0] e1);
        check({tag, " status"}, {16'h0, viol_status}, {16'h0, st});
        check({tag, " irq"}, {31'h0, irq}, {31'h0, (st != 16'h0)});
        check({tag, " fv_valid"}, {31'h0, first_viol_valid}, {31'h0, fv});
        check({tag, " fv_ch"}, {31'h0, first_viol_ch}, {31'h0, ch});
        check({tag, " fv_rule"}, {29'h0, first_viol_rule}, {29'h0, rule});
        check({tag, " xfer_cnt"}, xfer_cnt, {x1, x0});
        check({tag, " err_cnt"}, err_cnt, {e1, e0});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [27];

    initial begin
        // rows: v r e en clr d1 sz0 off0 sz1 | status fv ch rule x0 x1 e0
        tbl[0]  = mk(2'b01, 2'b00, 2'b00, 2'b11, 1'b0, DA, 3'd4, 2'd0, 3'd4, 16'h0000, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0, 16'd0);
        tbl[1]  = mk(2'b01, 2'b00, 2'b00, 2'b11, 1'b0, DA, 3'd4, 2'd0, 3'd4, 16'h0000, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0, 16'd0);
        tbl[2]  = mk(2'b00, 2'b00, 2'b00, 2'b11, 1'b0, DA, 3'd4, 2'd0, 3'd4, 16'h0001, 1'b1, 1'b0, 3'd0, 16'd0, 16'd0, 16'd0);
        tbl[3]  = mk(2'b00, 2'b00, 2'b00, 2'b11, 1'b1, DA, 3'd4, 2'd0, 3'd4, 16'h0000, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0, 16'd0);
        tbl[4]  = mk(2'b10, 2'b00, 2'b00, 2'b11, 1'b0, DA, 3'd4, 2'd0, 3'd4, 16'h0000, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0, 16'd0);
        tbl[5]  = mk(2'b10, 2'b00, 2'b00, 2'b11, 1'b0, D5, 3'd4, 2'd0, 3'd4, 16'h0200, 1'b1, 1'b1, 3'd1, 16'd0, 16'd0, 16'd0);
        tbl[6]  = mk(2'b10, 2'b10, 2'b00, 2'b11, 1'b0, D5, 3'd4, 2'd0, 3'd4, 16'h0200, 1'b1, 1'b1, 3'd1, 16'd0, 16'd1, 16'd0);
        tbl[7]  = mk(2'b00, 2'b00, 2'b00, 2'b11, 1'b1, D5, 3'd4, 2'd0, 3'd4, 16'h0000, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0, 16'd0);
        tbl[8]  = mk(2'b01, 2'b01, 2'b00, 2'b11, 1'b0, D5, 3'd3, 2'd2, 3'd4, 16'h0020, 1'b1, 1'b0, 3'd5, 16'd1, 16'd0, 16'd0);
        tbl[9]  = mk(2'b01, 2'b01, 2'b01, 2'b11, 1'b0, D5, 3'd2, 2'd2, 3'd4, 16'h0020, 1'b1, 1'b0, 3'd5, 16'd2, 16'd0, 16'd1);
        tbl[10] = mk(2'b01, 2'b01, 2'b00, 2'b11, 1'b0, D5, 3'd0, 2'd0, 3'd4, 16'h0030, 1'b1, 1'b0, 3'd5, 16'd3, 16'd0, 16'd1);
        tbl[11] = mk(2'b00, 2'b00, 2'b00, 2'b11, 1'b1, D5, 3'd4, 2'd0, 3'd4, 16'h0000, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0, 16'd0);
        tbl[12] = mk(2'b10, 2'b00, 2'b00, 2'b11, 1'b0, D5, 3'd4, 2'd0, 3'd4, 16'h0000, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0, 16'd0);
        tbl[13] = mk(2'b10, 2'b00, 2'b00, 2'b11, 1'b0, D5, 3'd4, 2'd0, 3'd4, 16'h0000, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0, 16'd0);
        tbl[14] = mk(2'b10, 2'b00, 2'b00, 2'b11, 1'b0, D5, 3'd4, 2'd0, 3'd4, 16'h0000, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0, 16'd0);
        tbl[15] = mk(2'b10, 2'b00, 2'b00, 2'b11, 1'b0, D5, 3'd4, 2'd0, 3'd4, 16'h8000, 1'b1, 1'b1, 3'd7, 16'd0, 16'd0, 16'd0);
        tbl[16] = mk(2'b10, 2'b00, 2'b00, 2'b11, 1'b1, D5, 3'd4, 2'd0, 3'd4, 16'h0000, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0, 16'd0);
        tbl[17] = mk(2'b10, 2'b00, 2'b00, 2'b11, 1'b0, D5, 3'd4, 2'd0, 3'd4, 16'h0000, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0, 16'd0);
        tbl[18] = mk(2'b10, 2'b10, 2'b00, 2'b11, 1'b0, D5, 3'd4, 2'd0, 3'd4, 16'h0000, 1'b0, 1'b0, 3'd0, 16'd0, 16'd1, 16'd0);
        tbl[19] = mk(2'b00, 2'b00, 2'b00, 2'b11, 1'b0, D5, 3'd4, 2'd0, 3'd4, 16'h0000, 1'b0, 1'b0, 3'd0, 16'd0, 16'd1, 16'd0);
        tbl[20] = mk(2'b10, 2'b00, 2'b00, 2'b11, 1'b0, D5, 3'd4, 2'd0, 3'd4, 16'h0000, 1'b0, 1'b0, 3'd0, 16'd0, 16'd1, 16'd0);
        tbl[21] = mk(2'b00, 2'b00, 2'b01, 2'b11, 1'b0, D5, 3'd4, 2'd0, 3'd4, 16'h0140, 1'b1, 1'b0, 3'd6, 16'd0, 16'd1, 16'd0);
        tbl[22] = mk(2'b10, 2'b10, 2'b00, 2'b11, 1'b1, D5, 3'd4, 2'd0, 3'd0, 16'h1000, 1'b1, 1'b1, 3'd4, 16'd0, 16'd1, 16'd0);
        tbl[23] = mk(2'b01, 2'b01, 2'b00, 2'b11, 1'b1, D5, 3'd4, 2'd0, 3'd4, 16'h0000, 1'b0, 1'b0, 3'd0, 16'd1, 16'd0, 16'd0);
        tbl[24] = mk(2'b00, 2'b00, 2'b00, 2'b11, 1'b0, D5, 3'd4, 2'd0, 3'd4, 16'h0000, 1'b0, 1'b0, 3'd0, 16'd1, 16'd0, 16'd0);
        tbl[25] = mk(2'b01, 2'b01, 2'b00, 2'b10, 1'b0, D5, 3'd0, 2'd0, 3'd4, 16'h0000, 1'b0, 1'b0, 3'd0, 16'd2, 16'd0, 16'd0);
        tbl[26] = mk(2'b00, 2'b00, 2'b00, 2'b11, 1'b1, D5, 3'd4, 2'd0, 3'd4, 16'h0000, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0, 16'd0);

        // Reset state
        reset_n = 1'b0; md_valid = 2'b00; md_ready = 2'b00; md_err = 2'b00;
        checks_enable = 2'b11; md_data = 64'h0; md_offset = 4'h0; md_size = 6'o44; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 16'h0, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        reset_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 27; i++) begin
            md_valid = tbl[i].v; md_ready = tbl[i].r; md_err = tbl[i].e;
            checks_enable = tbl[i].en; clr = tbl[i].c;
            md_data = {tbl[i].d1, 32'h00000011};
            md_size = {tbl[i].sz1, tbl[i].sz0};
            md_offset = {2'd0, tbl[i].off0};
            step();
            check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].fv, tbl[i].ch, tbl[i].rule,
                      tbl[i].x0, tbl[i].x1, tbl[i].e0, 16'd0);
        end

        // Counter saturation at all-ones, then clear coinciding with a transfer
        md_valid = 2'b01; md_ready = 2'b01; md_err = 2'b01; clr = 1'b0;
        md_size = {3'd4, 3'd4}; md_offset = 4'h0; checks_enable = 2'b11;
        repeat (65537) @(posedge clk);
        #1;
        check_all("saturate", 16'h0, 1'b0, 1'b0, 3'd0, 16'hFFFF, 16'd0, 16'hFFFF, 16'd0);
        clr = 1'b1;
        step();
        check_all("clr_with_xfer", 16'h0, 1'b0, 1'b0, 3'd0, 16'd1, 16'd0, 16'd1, 16'd0);
        md_valid = 2'b00; md_ready = 2'b00; md_err = 2'b00;
        step();
        check_all("clr_idle", 16'h0, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        clr = 1'b0;

        // Reset in the middle of a ch1 stall; new data afterwards is not R1
        md_valid = 2'b11; md_ready = 2'b00; md_data = {DA, 32'h00000011};
        md_size = {3'd4, 3'd0};
        step();
        check_all("pre_rst1", 16'h0010, 1'b1, 1'b0, 3'd4, 16'd0, 16'd0, 16'd0, 16'd0);
        step();
        check_all("pre_rst2", 16'h0010, 1'b1, 1'b0, 3'd4, 16'd0, 16'd0, 16'd0, 16'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check_all("in_rst_async", 16'h0, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        step();
        check_all("in_rst_edge", 16'h0, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        md_valid = 2'b10; md_data = {D5, 32'h00000011}; md_size = {3'd4, 3'd4};
        reset_n = 1'b1;
        step();
        check_all("post_rst1", 16'h0, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        step();
        check_all("post_rst2", 16'h0, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        md_ready = 2'b10;
        step();
        check_all("post_rst_xfer", 16'h0, 1'b0, 1'b0, 3'd0, 16'd0, 16'd1, 16'd0, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
